// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: one data-bus transaction per accepted op,
// store lane steering, load extraction/extension and misalign detection.
module load_store_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [2:0]        in_ls_flag,
  input  logic              in_mem_we,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_misalign,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [3:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data
);

  localparam logic [2:0] LS_NONE    = 3'd0;
  localparam logic [2:0] LS_BTYE    = 3'd1;
  localparam logic [2:0] LS_BTYE_U  = 3'd2;
  localparam logic [2:0] LS_HALFW   = 3'd3;
  localparam logic [2:0] LS_HALFW_U = 3'd4;
  localparam logic [2:0] LS_WORD    = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [2:0]          flag_q;
  logic                we_q;
  logic [1:0]          off_q;
  logic                stall_q, out_valid_q, out_misalign_q, dreq_valid_q;
  logic [DATA_W-1:0]   out_rdata_q, rdata_d;
  logic [ADDR_W-1:0]   dreq_addr_q;
  logic [1:0]          dreq_size_q;
  logic [3:0]          dreq_strobe_q;
  logic [DATA_W-1:0]   dreq_data_q;

  logic                accept_c, misalign_c, is_half_c, is_word_c;
  logic [ADDR_W-1:0]   req_addr_c;
  logic [1:0]          req_size_c;
  logic [3:0]          req_strobe_c;
  logic [DATA_W-1:0]   req_data_c;
  logic [DATA_W-1:0]   lane_c;

  // Decode the incoming op: acceptance, misalignment and bus request fields
  always_comb begin
    is_half_c    = (in_ls_flag == LS_HALFW) || (in_ls_flag == LS_HALFW_U);
    is_word_c    = (in_ls_flag == LS_WORD);
    accept_c     = in_valid && (in_ls_flag != LS_NONE) && (in_ls_flag <= LS_WORD);
    misalign_c   = (is_half_c && in_addr[0]) || (is_word_c && (in_addr[1:0] != 2'b00));
    req_addr_c   = in_addr;
    req_size_c   = 2'd0;
    req_strobe_c = 4'(4'b0001 << in_addr[1:0]);
    req_data_c   = {4{in_wdata[7:0]}};
    if (is_half_c) begin
      req_size_c   = 2'd1;
      req_strobe_c = 4'(4'b0011 << in_addr[1:0]);
      req_data_c   = {2{in_wdata[15:0]}};
    end else if (is_word_c) begin
      req_addr_c   = {in_addr[ADDR_W-1:2], 2'b00};
      req_size_c   = 2'd2;
      req_strobe_c = 4'hF;
      req_data_c   = in_wdata;
    end
    if (!in_mem_we) req_strobe_c = 4'b0000;
  end

  // Next-state logic and the load result that is captured on completion
  always_comb begin
    state_d = state_q;
    lane_c  = dresp_data >> {off_q, 3'b000};
    rdata_d = '0;
    case (state_q)
      S_IDLE: if (accept_c) state_d = misalign_c ? S_DONE : S_REQ;
      S_REQ:  if (dresp_addr_ok) state_d = dresp_data_ok ? S_DONE : S_WAIT;
      S_WAIT: if (dresp_data_ok) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!we_q) begin
      case (flag_q)
        LS_BTYE:    rdata_d = {{24{lane_c[7]}}, lane_c[7:0]};
        LS_BTYE_U:  rdata_d = {24'd0, lane_c[7:0]};
        LS_HALFW:   rdata_d = {{16{lane_c[15]}}, lane_c[15:0]};
        LS_HALFW_U: rdata_d = {16'd0, lane_c[15:0]};
        LS_WORD:    rdata_d = dresp_data;
        default:    rdata_d = '0;
      endcase
    end
  end

  // State, latched op and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      flag_q         <= LS_NONE;
      we_q           <= 1'b0;
      off_q          <= 2'b00;
      stall_q        <= 1'b0;
      out_valid_q    <= 1'b0;
      out_misalign_q <= 1'b0;
      out_rdata_q    <= '0;
      dreq_valid_q   <= 1'b0;
      dreq_addr_q    <= '0;
      dreq_size_q    <= 2'd0;
      dreq_strobe_q  <= 4'b0000;
      dreq_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      stall_q        <= (state_d == S_REQ) || (state_d == S_WAIT);
      dreq_valid_q   <= (state_d == S_REQ);
      out_valid_q    <= (state_d == S_DONE);
      out_misalign_q <= (state_q == S_IDLE) && accept_c && misalign_c;
      if ((state_q == S_IDLE) && accept_c) begin
        flag_q        <= in_ls_flag;
        we_q          <= in_mem_we;
        off_q         <= in_addr[1:0];
        dreq_addr_q   <= req_addr_c;
        dreq_size_q   <= req_size_c;
        dreq_strobe_q <= req_strobe_c;
        dreq_data_q   <= req_data_c;
        if (misalign_c) out_rdata_q <= '0;
      end
      if (((state_q == S_REQ) || (state_q == S_WAIT)) && (state_d == S_DONE))
        out_rdata_q <= rdata_d;
    end
  end

  assign stall        = stall_q;
  assign out_valid    = out_valid_q;
  assign out_rdata    = out_rdata_q;
  assign out_misalign = out_misalign_q;
  assign dreq_valid   = dreq_valid_q;
  assign dreq_addr    = dreq_addr_q;
  assign dreq_size    = dreq_size_q;
  assign dreq_strobe  = dreq_strobe_q;
  assign dreq_data    = dreq_data_q;

endmodule
